trig_series_seq: RTL
====================

# trig_series_seq

Multi-cycle, parametrised sine/cosine evaluator for the rose-curve datapath. It takes one signed fixed-point angle in radians per transaction and reduces it iteratively to [0, π/2] with sign tracking. It then evaluates a Taylor series term by term, using one multiply per cycle, and returns a signed fixed-point result. It sits between the angle sequencer and the polar-to-Cartesian stage, using valid/ready handshakes on both sides.

## Interface
- W, 32: width of angle and result words (two's complement).
- FRAC, 16: fractional bits of angle and result (Q(W-FRAC).FRAC).
- TERMS, 6: number of series terms (x, x³, … x^(2·TERMS−1)), range 2..10.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  angle/mode present.
- in_ready  output  1  block can accept; high only in IDLE.
- in_angle  input  W  signed angle in radians, Q.FRAC.
- in_mode  input  1  0 = sin, 1 = cos.
- out_valid  output  1  result present; held until consumed.
- out_ready  input  1  downstream accepts result.
- out_value  output  W  signed result, Q.FRAC, clamped to ±2^FRAC.

## Operation
- Constants, all rounded to nearest at elaboration:
  - PI = round(π·2^FRAC).
  - HPI = round(π/2·2^FRAC).
  - RECIP[k] = round(2^FRAC / ((2k)(2k+1))) for k = 1..TERMS−1.
- Internal datapath is W+2 bits signed. Products are full-width, followed by an arithmetic shift right by FRAC, truncating toward −∞.
- States: IDLE, REDUCE, FOLD, SQUARE, MULA, MULB, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch x = in_angle + (in_mode ? HPI : 0) and clear neg, then go to REDUCE.
- REDUCE, one adjustment per cycle:
  - If x < 0: x += PI, toggle neg.
  - Else if x ≥ PI: x −= PI, toggle neg.
  - Else go to FOLD without changing x.
- FOLD:
  - If x > HPI: x = PI − x.
  - Set term = x, acc = x, then go to SQUARE.
- SQUARE: x2 = (x·x)>>FRAC, k = 1, go to MULA.
- MULA: p = (term·x2)>>FRAC, go to MULB.
- MULB:
  - term = −((p·RECIP[k])>>FRAC), acc += term.
  - If k == TERMS−1, go to DONE; else k += 1 and go to MULA.
- DONE:
  - out_value = clamp(neg ? −acc : acc, −2^FRAC, +2^FRAC), out_valid = 1.
  - On out_ready, drop out_valid and return to IDLE. in_ready rises the cycle after.
- out_value is stable and unchanged from the first out_valid cycle until the handshake completes.
- in_angle and in_mode are sampled only at acceptance; later changes have no effect on the transaction in flight.

## Timing
- Reset (rst_n low at an edge): state = IDLE, in_ready = 1, out_valid = 0, out_value = 0, all internal registers cleared.
- Reset mid-transaction aborts it. No result is produced, and the block is ready on the first edge after rst_n returns high.
- Latency:
  - Let R = number of REDUCE adjustments.
  - From the accepting edge to the edge that raises out_valid is (R+1) + 1 + 1 + 2·(TERMS−1) cycles.
  - For 0 ≤ effective angle < PI with TERMS = 6, this is 13 cycles.
- Throughput: one transaction in flight. The next acceptance is no earlier than 1 cycle after the out handshake.
- Backpressure: with out_ready low, the block stays in DONE indefinitely with outputs frozen.
- Boundaries:
  - x == PI in REDUCE counts as out of range and is reduced to 0 with neg toggled.
  - x == HPI is not folded.
  - Negative inputs reduce upward. R is bounded by |angle|/PI + 1; no saturation is applied to the angle itself.
  - in_valid asserted while busy is ignored, since in_ready = 0.

## Test plan
- Reset, then sin of 0 (in_angle = 0, mode 0):
  - out_valid after exactly 13 cycles with TERMS = 6.
  - out_value = 0.
  - in_ready = 1 during reset and again one cycle after the out handshake.
- sin of π/6 (in_angle = 34315) -> out_value = 32768 ± 4. cos of 0 (mode 1) -> 65536 ± 4 (clamp may engage).
- sin of π/2 (102944) -> 65536 ± 4. sin of −π/2 (−102944) -> −65536 ± 4. sin of π (205887) -> 0 ± 4.
- sin of 10.0 rad (655360) -> −35652 ± 8. Latency rises by 3 reduction cycles relative to the first case.
- Backpressure: hold out_ready low 20 cycles after out_valid -> out_value is constant and in_ready stays 0. A new in_valid pulse during this time is not accepted.
- Assert rst_n low during MULA of a transaction -> out_valid never rises for it. A fresh sin(π/6) accepted right after reset returns 32768 ± 4.

Source files
------------

// File: rtl/trig_series_seq.sv
// Multi-cycle sine/cosine evaluator: iterative range reduction to [0, pi/2] with sign tracking,
// then a Taylor series evaluated term by term with one multiply per cycle.
module trig_series_seq #(
   parameter int W     = 32,
   parameter int FRAC  = 16,
   parameter int TERMS = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_angle,
   input  logic                in_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_value
);

   // state   | meaning
   // IDLE    | waiting for an angle, in_ready high
   // REDUCE  | one +/-PI adjustment per cycle until 0 <= x < PI
   // FOLD    | mirror x above HPI, seed term and accumulator
   // SQUARE  | x2 = x*x
   // MULA    | p = term*x2
   // MULB    | term = -p*RECIP[k], accumulate
   // DONE    | result held until out_ready
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] REDUCE = 3'd1;
   localparam logic [2:0] FOLD   = 3'd2;
   localparam logic [2:0] SQUARE = 3'd3;
   localparam logic [2:0] MULA   = 3'd4;
   localparam logic [2:0] MULB   = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam int DW = W + 2;
   typedef logic signed [DW-1:0] dat_t;

   localparam longint PI_L  = longint'(3.14159265358979323846 * (2.0 ** FRAC));
   localparam longint HPI_L = longint'(1.57079632679489661923 * (2.0 ** FRAC));
   localparam dat_t   PI_C  = dat_t'(PI_L);
   localparam dat_t   HPI_C = dat_t'(HPI_L);
   localparam dat_t   ONE_C = dat_t'(longint'(1) << FRAC);

   // Rounded-to-nearest 1/((2k)(2k+1)); only ever called with constant k.
   function automatic dat_t recip(input int k);
      longint d;
      d = longint'(2 * k) * longint'(2 * k + 1);
      return dat_t'(((longint'(1) << FRAC) + d / 2) / d);
   endfunction

   // Full-width signed product, arithmetic shift (floor), truncated back to DW.
   function automatic dat_t mul_shift(input dat_t a, input dat_t b);
      logic signed [2*DW-1:0] p;
      p = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
      p = p >>> FRAC;
      return p[DW-1:0];
   endfunction

   logic [2:0]         state_q, state_d;
   dat_t               x_q, x_d;
   dat_t               x2_q, x2_d;
   dat_t               term_q, term_d;
   dat_t               acc_q, acc_d;
   dat_t               p_q, p_d;
   logic               neg_q, neg_d;
   logic [3:0]         k_q, k_d;
   logic signed [W-1:0] out_value_q, out_value_d;

   dat_t recip_sel;
   dat_t term_new;
   dat_t acc_new;
   dat_t signed_res;
   dat_t clamped;

   always_comb begin
      recip_sel = '0;
      for (int k = 1; k < TERMS; k++) begin
         if (k_q == 4'(k)) recip_sel = recip(k);
      end
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      x2_d        = x2_q;
      term_d      = term_q;
      acc_d       = acc_q;
      p_d         = p_q;
      neg_d       = neg_q;
      k_d         = k_q;
      out_value_d = out_value_q;
      term_new    = -mul_shift(p_q, recip_sel);
      acc_new     = acc_q + term_new;
      signed_res  = neg_q ? -acc_new : acc_new;
      if (signed_res > ONE_C)       clamped = ONE_C;
      else if (signed_res < -ONE_C) clamped = -ONE_C;
      else                          clamped = signed_res;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = dat_t'(in_angle) + (in_mode ? HPI_C : dat_t'(0));
               neg_d   = 1'b0;
               state_d = REDUCE;
            end
         end
         REDUCE: begin
            if (x_q < 0) begin
               x_d   = x_q + PI_C;
               neg_d = ~neg_q;
            end else if (x_q >= PI_C) begin
               x_d   = x_q - PI_C;
               neg_d = ~neg_q;
            end else begin
               state_d = FOLD;
            end
         end
         FOLD: begin
            if (x_q > HPI_C) begin
               x_d    = PI_C - x_q;
               term_d = PI_C - x_q;
               acc_d  = PI_C - x_q;
            end else begin
               term_d = x_q;
               acc_d  = x_q;
            end
            state_d = SQUARE;
         end
         SQUARE: begin
            x2_d    = mul_shift(x_q, x_q);
            k_d     = 4'd1;
            state_d = MULA;
         end
         MULA: begin
            p_d     = mul_shift(term_q, x2_q);
            state_d = MULB;
         end
         MULB: begin
            term_d = term_new;
            acc_d  = acc_new;
            if (k_q == 4'(TERMS - 1)) begin
               out_value_d = clamped[W-1:0];
               state_d     = DONE;
            end else begin
               k_d     = k_q + 4'd1;
               state_d = MULA;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         x2_q        <= '0;
         term_q      <= '0;
         acc_q       <= '0;
         p_q         <= '0;
         neg_q       <= 1'b0;
         k_q         <= '0;
         out_value_q <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         x2_q        <= x2_d;
         term_q      <= term_d;
         acc_q       <= acc_d;
         p_q         <= p_d;
         neg_q       <= neg_d;
         k_q         <= k_d;
         out_value_q <= out_value_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_value = out_value_q;

endmodule
